// File: rtl/ce_sched_if.sv
// Configuration port of the ce_sched clock-enable scheduler.
// The requester drives req/ch/in/out and watches busy/ack/err.
interface ce_sched_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned W      = 28
);
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic           CFG_REQ;
    logic [CHW-1:0] CFG_CH;
    logic [W-1:0]   CFG_IN;
    logic [W-1:0]   CFG_OUT;
    logic           CFG_BUSY;
    logic           CFG_ACK;
    logic           CFG_ERR;

    modport master (
        output CFG_REQ, CFG_CH, CFG_IN, CFG_OUT,
        input  CFG_BUSY, CFG_ACK, CFG_ERR
    );

    modport slave (
        input  CFG_REQ, CFG_CH, CFG_IN, CFG_OUT,
        output CFG_BUSY, CFG_ACK, CFG_ERR
    );
endinterface

// File: rtl/ce_sched.sv
// Multi-channel fractional clock-enable scheduler with a staged, glitch-free ratio update port.
// Optional per-channel CE counters with a readback port when CE_SCHED_CNT_EN is defined.
module ce_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned W      = 28,
    localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] CH_EN,
    ce_sched_if.slave         cfg,
    output logic [NUM_CH-1:0] CE
`ifdef CE_SCHED_CNT_EN
    ,
    input  logic [CHW-1:0]    CNT_SEL,
    output logic [15:0]       CNT_OUT
`endif
);

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] stg_ch_q, stg_ch_d;
    logic [W-1:0]   stg_in_q, stg_in_d;
    logic [W-1:0]   stg_out_q, stg_out_d;
    logic           busy_q, busy_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;

    logic [W-1:0]   in_q  [NUM_CH];
    logic [W-1:0]   in_d  [NUM_CH];
    logic [W-1:0]   out_q [NUM_CH];
    logic [W-1:0]   out_d [NUM_CH];
    logic [W-1:0]   sum_q [NUM_CH];
    logic [W-1:0]   sum_d [NUM_CH];
    logic [W-1:0]   dif   [NUM_CH];
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] tgt;

    logic apply;
    logic req_ok;

    // Phase test per channel and the safe-point condition for the staged target
    always_comb begin
        apply = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            dif[i]  = sum_q[i] + out_q[i] - in_q[i];
            qual[i] = CH_EN[i] & ~dif[i][W-1];
            tgt[i]  = (CHW'(i) == stg_ch_q);
            if (tgt[i] && (qual[i] || !CH_EN[i])) begin
                apply = (state_q == S_PEND);
            end
        end
    end

    assign req_ok = (cfg.CFG_OUT != '0) && (cfg.CFG_OUT <= cfg.CFG_IN) &&
                    !cfg.CFG_IN[W-1] && (32'(cfg.CFG_CH) < NUM_CH);

    // Config FSM: stage a valid ratio, then hold it until the target reaches a safe point
    always_comb begin
        state_d   = state_q;
        stg_ch_d  = stg_ch_q;
        stg_in_d  = stg_in_q;
        stg_out_d = stg_out_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg.CFG_REQ) begin
                    if (req_ok) begin
                        stg_ch_d  = cfg.CFG_CH;
                        stg_in_d  = cfg.CFG_IN;
                        stg_out_d = cfg.CFG_OUT;
                        busy_d    = 1'b1;
                        state_d   = S_PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (apply) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulators; an applied config restarts its channel at phase 0 after the old-ratio CE
    always_comb begin
        ce_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_d[i]  = in_q[i];
            out_d[i] = out_q[i];
            if (!CH_EN[i]) begin
                sum_d[i] = '0;
            end else if (qual[i]) begin
                sum_d[i] = dif[i];
                ce_d[i]  = 1'b1;
            end else begin
                sum_d[i] = sum_q[i] + out_q[i];
            end
            if (apply && tgt[i]) begin
                in_d[i]  = stg_in_q;
                out_d[i] = stg_out_q;
                sum_d[i] = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            stg_ch_q  <= '0;
            stg_in_q  <= '0;
            stg_out_q <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ce_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                in_q[i]  <= W'(1);
                out_q[i] <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            stg_ch_q  <= stg_ch_d;
            stg_in_q  <= stg_in_d;
            stg_out_q <= stg_out_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ce_q      <= ce_d;
            for (int i = 0; i < NUM_CH; i++) begin
                in_q[i]  <= in_d[i];
                out_q[i] <= out_d[i];
                sum_q[i] <= sum_d[i];
            end
        end
    end

    assign CE           = ce_q;
    assign cfg.CFG_BUSY = busy_q;
    assign cfg.CFG_ACK  = ack_q;
    assign cfg.CFG_ERR  = err_q;

`ifdef CE_SCHED_CNT_EN
    logic [15:0] cnt_q [NUM_CH];
    logic [15:0] cnt_d [NUM_CH];
    logic [15:0] cnt_out_q, cnt_out_d;

    // Wrapping CE counters, cleared when a new ratio lands on the channel
    always_comb begin
        cnt_out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ce_d[i]) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            if (apply && tgt[i]) begin
                cnt_d[i] = '0;
            end
            if (CHW'(i) == CNT_SEL) begin
                cnt_out_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_out_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_out_q <= cnt_out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign CNT_OUT = cnt_out_q;
`endif

endmodule

// File: tb/tb_ce_sched.sv
// Scoreboard bench for ce_sched: expected ACK/ERR events are queued at issue time and
// checked by a monitor; CE pulse trains are logged per cycle and compared to hand-derived patterns.
module tb_ce_sched;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned W      = 28;
    localparam int unsigned CHW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ce;

    ce_sched_if #(.NUM_CH(NUM_CH), .W(W)) cfg_if ();

`ifdef CE_SCHED_CNT_EN
    logic [CHW-1:0] cnt_sel;
    logic [15:0]    cnt_out;
`endif

    ce_sched #(.NUM_CH(NUM_CH), .W(W)) dut (
        .CLK     (clk),
        .RST     (rst),
        .CH_EN   (ch_en),
        .cfg     (cfg_if),
        .CE      (ce)
`ifdef CE_SCHED_CNT_EN
        ,
        .CNT_SEL (cnt_sel),
        .CNT_OUT (cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CE history, one entry per cycle, sampled on the falling edge
    logic [NUM_CH-1:0] ce_log [8192];
    always @(negedge clk) begin
        if (cyc < 8192) ce_log[cyc] = ce;
    end

    typedef struct {
        bit is_ack;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Scoreboard monitor for ACK/ERR pulses
    always @(negedge clk) begin
        if (cfg_if.CFG_ACK || cfg_if.CFG_ERR) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cfg_evt", longint'({cfg_if.CFG_ACK, cfg_if.CFG_ERR}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cfg_evt_kind", longint'({cfg_if.CFG_ACK, cfg_if.CFG_ERR}), mon_e.is_ack ? 2 : 1);
                chk("cfg_evt_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input longint in_v, input longint out_v);
        cfg_if.CFG_REQ = 1'b1;
        cfg_if.CFG_CH  = CHW'(ch);
        cfg_if.CFG_IN  = W'(in_v);
        cfg_if.CFG_OUT = W'(out_v);
        @(negedge clk);
        cfg_if.CFG_REQ = 1'b0;
    endtask

    task automatic wait_ce0(input string name);
        int found;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (ce[0]) begin
                found = 1;
                break;
            end
            tick(1);
        end
        chk(name, found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, n, m, n2, r, bad, cnt;

        rst            = 1'b1;
        ch_en          = '0;
        cfg_if.CFG_REQ = 1'b0;
        cfg_if.CFG_CH  = '0;
        cfg_if.CFG_IN  = '0;
        cfg_if.CFG_OUT = '0;
`ifdef CE_SCHED_CNT_EN
        cnt_sel = '0;
`endif
        tick(3);
        chk("rst_ce", ce, 0);
        chk("rst_busy", cfg_if.CFG_BUSY, 0);
        chk("rst_ack", cfg_if.CFG_ACK, 0);
        chk("rst_err", cfg_if.CFG_ERR, 0);
        rst = 1'b0;
        tick(2);

        // ch0 = 1/3 and ch1 = 2/5 configured while disabled, then both started together
        c = cyc;
        exp_q.push_back('{1'b1, c + 2});
        send(0, 3, 1);
        chk("busy_after_accept", cfg_if.CFG_BUSY, 1);
        tick(1);
        chk("busy_after_apply", cfg_if.CFG_BUSY, 0);
        tick(1);
        c = cyc;
        exp_q.push_back('{1'b1, c + 2});
        send(1, 5, 2);
        tick(2);
        n = cyc;
        ch_en = 4'b0011;
        tick(1001);

        cnt = 0;
        for (int k = n + 1; k <= n + 300; k++) cnt += int'(ce_log[k][0]);
        chk("ch0_pulses_300", cnt, 100);
        cnt = 0;
        for (int k = n + 1; k <= n + 1000; k++) cnt += int'(ce_log[k][1]);
        chk("ch1_pulses_1000", cnt, 400);
        bad = 0;
        for (int k = n + 1; k <= n + 1000; k++) begin
            if (ce_log[k][0] != (((k - n) % 3) == 0)) bad++;
        end
        chk("ch0_period3_bad", bad, 0);

        // Mid-period ratio change on ch0 to 1/2: held until ch0's next CE
        wait_ce0("ce0_seen_before_change");
        m = cyc;
        exp_q.push_back('{1'b1, m + 3});
        send(0, 2, 1);
        chk("pend_busy_m1", cfg_if.CFG_BUSY, 1);
        chk("pend_ce0_m1", ce[0], 0);
        tick(1);
        chk("pend_busy_m2", cfg_if.CFG_BUSY, 1);
        chk("pend_ce0_m2", ce[0], 0);
        tick(1);
        chk("apply_busy_m3", cfg_if.CFG_BUSY, 0);
        chk("apply_ce0_m3", ce[0], 1);
        tick(2);

        // Invalid ratios: OUT=0, OUT>IN, IN=2^(W-1)
        c = cyc;
        exp_q.push_back('{1'b0, c + 1});
        send(0, 3, 0);
        chk("err_out0_busy", cfg_if.CFG_BUSY, 0);
        c = cyc;
        exp_q.push_back('{1'b0, c + 1});
        send(0, 5, 7);
        chk("err_out_gt_in_busy", cfg_if.CFG_BUSY, 0);
        c = cyc;
        exp_q.push_back('{1'b0, c + 1});
        send(0, 64'd1 << 27, 1);
        chk("err_in_big_busy", cfg_if.CFG_BUSY, 0);

        while (cyc < m + 120) tick(1);
        bad = 0;
        for (int k = m + 1; k <= m + 110; k++) begin
            if (ce_log[k][0] != ((k >= m + 3) && (((k - m - 3) % 2) == 0))) bad++;
        end
        chk("ch0_change_pattern_bad", bad, 0);
        bad = 0;
        for (int k = n + 1; k <= m + 110; k++) begin
            if (ce_log[k][1] != ((((k - n) % 5) == 0) || (((k - n) % 5) == 3))) bad++;
        end
        chk("ch1_undisturbed_bad", bad, 0);

        // Disabled ch2 applies on the edge after acceptance; a request during PEND is dropped
        c = cyc;
        exp_q.push_back('{1'b1, c + 2});
        send(2, 4, 1);
        chk("ch2_busy", cfg_if.CFG_BUSY, 1);
        cfg_if.CFG_REQ = 1'b1;
        cfg_if.CFG_CH  = CHW'(2);
        cfg_if.CFG_IN  = W'(4);
        cfg_if.CFG_OUT = '0;
        tick(1);
        cfg_if.CFG_REQ = 1'b0;
        chk("ch2_busy_cleared", cfg_if.CFG_BUSY, 0);
        tick(3);
        n2 = cyc;
        ch_en[2] = 1'b1;
        tick(14);
        bad = 0;
        for (int k = n2 + 1; k <= n2 + 12; k++) begin
            if (ce_log[k][2] != (((k - n2) % 4) == 0)) bad++;
        end
        chk("ch2_period4_bad", bad, 0);

        // ch3 still has OUT=0, so a request against it stays pending until reset
        ch_en[3] = 1'b1;
        send(3, 4, 1);
        tick(10);
        chk("ch3_pend_busy", cfg_if.CFG_BUSY, 1);
        wait_ce0("ce0_seen_before_rst");
        #1 rst = 1'b1;
        #1;
        chk("async_rst_ce", ce, 0);
        chk("async_rst_busy", cfg_if.CFG_BUSY, 0);
        tick(2);
        rst = 1'b0;
        r = cyc;
        tick(21);
        bad = 0;
        for (int k = r + 1; k <= r + 20; k++) begin
            if (ce_log[k] != '0) bad++;
        end
        chk("post_rst_ce_silent", bad, 0);
        chk("post_rst_busy", cfg_if.CFG_BUSY, 0);

`ifdef CE_SCHED_CNT_EN
        ch_en = '0;
        tick(1);
        c = cyc;
        exp_q.push_back('{1'b1, c + 2});
        send(0, 3, 1);
        tick(2);
        cnt_sel = '0;
        ch_en[0] = 1'b1;
        tick(300);
        ch_en[0] = 1'b0;
        tick(3);
        chk("cnt_ch0_100", cnt_out, 100);
        c = cyc;
        exp_q.push_back('{1'b1, c + 2});
        send(0, 2, 1);
        tick(3);
        chk("cnt_cleared_on_apply", cnt_out, 0);
`endif

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ce_sched.md
Name: ce_sched

Overview:
- Multi-channel fractional clock-enable scheduler: NUM_CH phase-accumulator CE generators, each producing CE at average rate OUT/IN of CLK.
- Owns a single shared configuration port that stages new ratios and applies them only at a safe point: the channel's next CE, or immediately if the channel is disabled.
- Sits between the system/video-mode control logic and the core clock domains (CPU/VDP/SCSP enables). Gives glitch-free ratio changes with a req/ack handshake.

Parameters:
- NUM_CH, 4, number of CE channels (1..8).
- W, 28, accumulator and ratio width in bits.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- CH_EN  in  NUM_CH  per-channel run enable.
- CFG_REQ  in  1  configuration request; sampled each cycle.
- CFG_CH  in  clog2(NUM_CH) (min 1)  target channel.
- CFG_IN  in  W  new input-clock value (denominator).
- CFG_OUT  in  W  new output-clock value (numerator).
- CFG_BUSY  out  1  a staged config is pending.
- CFG_ACK  out  1  one-cycle pulse when the staged ratio takes effect.
- CFG_ERR  out  1  one-cycle pulse when a request is rejected.
- CE  out  NUM_CH  registered clock-enable pulses.

Behaviour:
- Reset (async assert; sync-style release on the next CLK edge):
  - every channel: IN=1, OUT=0, SUM=0, CE=0;
  - CFG_BUSY=0, CFG_ACK=0, CFG_ERR=0;
  - config FSM = IDLE.
- Per-channel accumulator, each cycle while CH_EN[i]=1:
  - DIF = SUM + OUT - IN, computed W bits wide, two's complement.
  - If DIF[W-1]==0: SUM<=DIF and CE[i]<=1.
  - Otherwise: SUM<=SUM+OUT and CE[i]<=0.
  - CE is registered: it appears the cycle after the qualifying edge.
- CH_EN[i]=0: SUM<=0 and CE[i]<=0; the channel restarts from phase 0 when re-enabled.
- Validity rule: 0 < CFG_OUT <= CFG_IN and CFG_IN < 2^(W-1). An OUT of 0 is rejected; a channel is stopped with CH_EN instead.
- Config FSM, IDLE:
  - CFG_REQ=1 with an invalid ratio: CFG_ERR pulses next cycle; stay IDLE.
  - CFG_REQ=1 with a valid ratio: latch CH, IN and OUT into stage registers; CFG_BUSY<=1; go to PEND.
- Config FSM, PEND:
  - CFG_REQ is ignored: no ack, no error. The requester must wait for CFG_BUSY=0.
  - Apply condition, evaluated each cycle: (the target channel's accumulator qualifies for CE this cycle) OR (CH_EN[target]=0).
  - On apply:
    - the qualifying CE (if any) is still produced with the old ratio;
    - the channel's IN/OUT are loaded from stage and SUM<=0;
    - CFG_ACK pulses that same edge; CFG_BUSY<=0; go to IDLE.
  - The new ratio governs the channel from the following cycle.
- Simultaneous events: in the apply cycle a fresh CFG_REQ is not accepted, because the FSM is still in PEND at that edge. It is accepted in the next cycle at the earliest.
- Other channels are never disturbed by configuration of one channel.
- Mid-PEND CH_EN drop: the pending config applies on the next edge.
- RST during PEND: the stage is discarded and no ACK is produced.
- Arithmetic: all sums modulo 2^W; no overflow is possible under the validity rule.

Optional Feature:
- Macro CE_SCHED_CNT_EN.
- Defined:
  - adds a per-channel 16-bit wrapping CE counter, incremented on each CE[i];
  - counter is cleared by RST and when a config is applied to that channel;
  - adds ports CNT_SEL (in, clog2(NUM_CH)) and CNT_OUT (out, 16), where CNT_OUT is the registered count of the selected channel, 1-cycle latency.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Config ch0 IN=3, OUT=1, CH_EN=1 -> ACK on first apply; thereafter CE[0] exactly every 3rd cycle, 100 pulses in 300 cycles.
- Config ch1 IN=5, OUT=2 -> CE[1] pattern repeats with period 5 and contains exactly 2 pulses per 5 cycles, measured over 1000 cycles (400 pulses).
- Ch0 running 1/3, then request IN=2, OUT=1 mid-period:
  - CFG_BUSY stays high until ch0's next CE, and ACK coincides with it;
  - old spacing of 3 holds up to that pulse;
  - spacing of 2 follows it;
  - other channels' CE is unchanged.
- Request with OUT=0, with OUT=7/IN=5, and with IN=2^27 -> CFG_ERR pulse each time, no BUSY, ratios unchanged.
- Ch2 with CH_EN=0, request IN=4, OUT=1 -> ACK on the edge after acceptance. Second CFG_REQ while BUSY -> ignored, no ACK or ERR.
- Assert RST while PEND -> all outputs 0 immediately (async), no ACK after release, CE all 0 until reconfigured.
- (CE_SCHED_CNT_EN) Ch0 at 1/3 for 300 cycles -> CNT_OUT=100 with CNT_SEL=0; after reconfig apply -> CNT_OUT=0.
